// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: make/break/E0 parser, shift and caps-lock tracking,
// a level code for the KBD register and a show-ahead FIFO of key presses.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter bit REPEAT_EN  = 1'b1,
  parameter int CODE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_ready,
  input  logic [7:0]        scan_code,
  output logic [CODE_W-1:0] key_out,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_data,
  input  logic              key_ready,
  output logic              overflow,
  output logic              shift,
  output logic              caps_lock
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

  state_t      state;
  logic [1:0]  edge_q;
  logic        evt;
  logic        lshift, rshift, caps_held;
  logic        held_valid;
  logic [8:0]  held_key;

  logic        do_make, do_brk, is_ext;
  logic [7:0]  xcode;
  logic [8:0]  key_id;
  logic        held_match, mapped, push, push_ok, pop, full;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Letters carry only the lowercase glyph; uppercase is derived by subtracting 32.
  function automatic logic [7:0] xlate(input logic [7:0] sc, input logic ext,
                                       input logic sh, input logic cp);
    logic [7:0] lo, hi, r;
    logic       alpha;
    lo = '0; hi = '0; r = '0; alpha = 1'b0;
    if (ext) begin
      case (sc)
        8'h6B: r = 8'd130;  8'h75: r = 8'd131;  8'h74: r = 8'd132;
        8'h72: r = 8'd133;  8'h6C: r = 8'd134;  8'h69: r = 8'd135;
        8'h7D: r = 8'd136;  8'h7A: r = 8'd137;  8'h70: r = 8'd138;
        8'h71: r = 8'd139;  8'h4A: r = 8'd47;   8'h5A: r = 8'd128;
        default: r = '0;
      endcase
    end else begin
      case (sc)
        8'h1C: begin lo = "a"; alpha = 1'b1; end  8'h32: begin lo = "b"; alpha = 1'b1; end
        8'h21: begin lo = "c"; alpha = 1'b1; end  8'h23: begin lo = "d"; alpha = 1'b1; end
        8'h24: begin lo = "e"; alpha = 1'b1; end  8'h2B: begin lo = "f"; alpha = 1'b1; end
        8'h34: begin lo = "g"; alpha = 1'b1; end  8'h33: begin lo = "h"; alpha = 1'b1; end
        8'h43: begin lo = "i"; alpha = 1'b1; end  8'h3B: begin lo = "j"; alpha = 1'b1; end
        8'h42: begin lo = "k"; alpha = 1'b1; end  8'h4B: begin lo = "l"; alpha = 1'b1; end
        8'h3A: begin lo = "m"; alpha = 1'b1; end  8'h31: begin lo = "n"; alpha = 1'b1; end
        8'h44: begin lo = "o"; alpha = 1'b1; end  8'h4D: begin lo = "p"; alpha = 1'b1; end
        8'h15: begin lo = "q"; alpha = 1'b1; end  8'h2D: begin lo = "r"; alpha = 1'b1; end
        8'h1B: begin lo = "s"; alpha = 1'b1; end  8'h2C: begin lo = "t"; alpha = 1'b1; end
        8'h3C: begin lo = "u"; alpha = 1'b1; end  8'h2A: begin lo = "v"; alpha = 1'b1; end
        8'h1D: begin lo = "w"; alpha = 1'b1; end  8'h22: begin lo = "x"; alpha = 1'b1; end
        8'h35: begin lo = "y"; alpha = 1'b1; end  8'h1A: begin lo = "z"; alpha = 1'b1; end
        8'h16: begin lo = "1"; hi = "!"; end      8'h1E: begin lo = "2"; hi = "@"; end
        8'h26: begin lo = "3"; hi = "#"; end      8'h25: begin lo = "4"; hi = "$"; end
        8'h2E: begin lo = "5"; hi = "%"; end      8'h36: begin lo = "6"; hi = "^"; end
        8'h3D: begin lo = "7"; hi = "&"; end      8'h3E: begin lo = "8"; hi = "*"; end
        8'h46: begin lo = "9"; hi = "("; end      8'h45: begin lo = "0"; hi = ")"; end
        8'h0E: begin lo = 8'd96; hi = 8'd126; end 8'h4E: begin lo = 8'd45; hi = 8'd95; end
        8'h55: begin lo = 8'd61; hi = 8'd43;  end 8'h5D: begin lo = 8'd92; hi = 8'd124; end
        8'h54: begin lo = 8'd91; hi = 8'd123; end 8'h5B: begin lo = 8'd93; hi = 8'd125; end
        8'h4C: begin lo = 8'd59; hi = 8'd58;  end 8'h52: begin lo = 8'd39; hi = 8'd34; end
        8'h41: begin lo = 8'd44; hi = 8'd60;  end 8'h49: begin lo = 8'd46; hi = 8'd62; end
        8'h4A: begin lo = 8'd47; hi = 8'd63;  end 8'h29: lo = 8'd32;
        8'h5A: lo = 8'd128;  8'h66: lo = 8'd129;  8'h76: lo = 8'd140;  8'h0D: lo = 8'd9;
        8'h05: lo = 8'd141;  8'h06: lo = 8'd142;  8'h04: lo = 8'd143;  8'h0C: lo = 8'd144;
        8'h03: lo = 8'd145;  8'h0B: lo = 8'd146;  8'h83: lo = 8'd147;  8'h0A: lo = 8'd148;
        8'h01: lo = 8'd149;  8'h09: lo = 8'd150;  8'h78: lo = 8'd151;  8'h07: lo = 8'd152;
        8'h70: lo = "0";  8'h69: lo = "1";  8'h72: lo = "2";  8'h7A: lo = "3";
        8'h6B: lo = "4";  8'h73: lo = "5";  8'h74: lo = "6";  8'h6C: lo = "7";
        8'h75: lo = "8";  8'h7D: lo = "9";  8'h71: lo = ".";  8'h7C: lo = "*";
        8'h7B: lo = "-";  8'h79: lo = "+";
        default: lo = '0;
      endcase
      if (alpha)
        r = (sh ^ cp) ? lo - 8'd32 : lo;
      else
        r = (sh && hi != 8'd0) ? hi : lo;
    end
    return r;
  endfunction

  assign evt = (edge_q == 2'b01);

  always_comb begin
    do_make = 1'b0;
    do_brk  = 1'b0;
    is_ext  = 1'b0;
    if (evt) begin
      case (state)
        S_IDLE: begin
          if (scan_code != 8'hE0 && scan_code != 8'hF0 && scan_code != 8'h00 &&
              scan_code != 8'hAA && scan_code != 8'hFA && scan_code != 8'hFE &&
              scan_code != 8'hFF)
            do_make = 1'b1;
        end
        S_EXT: begin
          is_ext  = 1'b1;
          do_make = (scan_code != 8'hF0);
        end
        S_BRK: do_brk = 1'b1;
        S_EXTBRK: begin
          is_ext = 1'b1;
          do_brk = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign shift      = lshift | rshift;
  assign xcode      = xlate(scan_code, is_ext, shift, caps_lock);
  assign key_id     = {is_ext, scan_code};
  assign held_match = held_valid && (held_key == key_id);
  assign mapped     = (xcode != 8'd0);
  assign push       = do_make && mapped && (REPEAT_EN || !held_match);
  assign key_valid  = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = key_valid && key_ready;
  assign push_ok    = push && (!full || pop);
  assign key_data   = key_valid ? CODE_W'(mem[rd_ptr]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      edge_q     <= '0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_held  <= 1'b0;
      caps_lock  <= 1'b0;
      held_valid <= 1'b0;
      held_key   <= '0;
      key_out    <= '0;
    end else begin
      edge_q <= {edge_q[0], scan_ready};
      if (evt) begin
        case (state)
          S_IDLE:  state <= (scan_code == 8'hE0) ? S_EXT :
                            (scan_code == 8'hF0) ? S_BRK : S_IDLE;
          S_EXT:   state <= (scan_code == 8'hF0) ? S_EXTBRK : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      if (do_make) begin
        if (!is_ext) begin
          if (scan_code == 8'h12) lshift <= 1'b1;
          if (scan_code == 8'h59) rshift <= 1'b1;
          // Typematic repeats of caps lock arrive as further makes; only the first toggles.
          if (scan_code == 8'h58 && !caps_held) begin
            caps_lock <= ~caps_lock;
            caps_held <= 1'b1;
          end
        end
        if (mapped) begin
          key_out    <= CODE_W'(xcode);
          held_key   <= key_id;
          held_valid <= 1'b1;
        end
      end
      if (do_brk) begin
        if (!is_ext) begin
          if (scan_code == 8'h12) lshift    <= 1'b0;
          if (scan_code == 8'h59) rshift    <= 1'b0;
          if (scan_code == 8'h58) caps_held <= 1'b0;
        end
        if (held_match) begin
          key_out    <= '0;
          held_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= xcode;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: one instance with typematic pushes enabled,
// one with them disabled, both fed the same byte stream.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       reset, scan_ready, key_ready;
  logic [7:0] scan_code;

  logic [7:0] key_out1, key_data1, key_out0, key_data0;
  logic       key_valid1, overflow1, shift1, caps1;
  logic       key_valid0, overflow0, shift0, caps0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1'b1), .CODE_W(8)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .key_out(key_out1), .key_valid(key_valid1), .key_data(key_data1),
    .key_ready(key_ready), .overflow(overflow1), .shift(shift1), .caps_lock(caps1)
  );

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1'b0), .CODE_W(8)) dut_norep (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .key_out(key_out0), .key_valid(key_valid0), .key_data(key_data0),
    .key_ready(key_ready), .overflow(overflow0), .shift(shift0), .caps_lock(caps0)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] ko_e, ko_e1;

  always @(negedge clk) begin
    if (!reset && key_valid1 && key_ready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL fifo_rep: unexpected entry %0d, required none", key_data1);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        if (key_data1 !== e) begin
          n_err++;
          $display("FAIL fifo_rep: got %0d, required %0d", key_data1, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && key_valid0 && key_ready) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL fifo_norep: unexpected entry %0d, required none", key_data0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (key_data0 !== e) begin
          n_err++;
          $display("FAIL fifo_norep: got %0d, required %0d", key_data0, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic exp_push(input logic [7:0] c, input bit both);
    q1.push_back(c);
    if (both) q0.push_back(c);
  endtask

  // One byte event; with pop set, key_ready is high only in the event cycle.
  task automatic send(input logic [7:0] b, input bit pop);
    @(posedge clk); #1;
    scan_code  = b;
    scan_ready = 1'b1;
    @(posedge clk); #1;
    ko_e = key_out1;
    if (pop) key_ready = 1'b1;
    @(posedge clk); #1;
    ko_e1 = key_out1;
    if (pop) key_ready = 1'b0;
    @(posedge clk); #1;
    scan_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_key_out",   key_out1,   0);
    chk("rst_key_valid", key_valid1, 0);
    chk("rst_key_data",  key_data1,  0);
    chk("rst_overflow",  overflow1,  0);
    chk("rst_shift",     shift1,     0);
    chk("rst_caps",      caps1,      0);
  endtask

  task automatic drain;
    key_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (q1.size() == 0 && q0.size() == 0 && !key_valid1 && !key_valid0) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q1.size() != 0 || q0.size() != 0 || key_valid1 || key_valid0) begin
      n_err++;
      $display("FAIL drain: pending %0d/%0d valid %0d/%0d, required all 0",
               q1.size(), q0.size(), key_valid1, key_valid0);
    end
    q1.delete();
    q0.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; key_ready = 1'b1;
    repeat (3) @(posedge clk);
    do_reset();

    // make/break, ignored and unmapped bytes, last-pressed-wins
    exp_push(8'd97, 1'b1);
    send(8'h1C, 1'b0);
    chk("t1_key_out_at_E",  ko_e,  0);
    chk("t1_key_out_at_E1", ko_e1, 97);
    chk("t1_norep_key_out", key_out0, 97);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    chk("t1_break", key_out1, 0);
    exp_push(8'd97, 1'b1);
    send(8'h1C, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h14, 1'b0);
    chk("t1_ignored_unmapped", key_out1, 97);
    exp_push(8'd98, 1'b1);
    send(8'h32, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    chk("t1_other_break", key_out1, 98);
    send(8'hF0, 1'b0); send(8'h32, 1'b0);
    chk("t1_held_break", key_out1, 0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0);
    drain();

    // shift and caps lock
    do_reset();
    send(8'h12, 1'b0);
    chk("t2_lshift", shift1, 1);
    exp_push(8'd64, 1'b1);
    send(8'h1E, 1'b0);
    chk("t2_at_sign", key_out1, 64);
    send(8'h58, 1'b0); send(8'hF0, 1'b0); send(8'h58, 1'b0);
    chk("t2_caps_on", caps1, 1);
    chk("t2_norep_caps", caps0, 1);
    exp_push(8'd97, 1'b1);
    send(8'h1C, 1'b0);
    chk("t2_shift_caps_letter", key_out1, 97);
    send(8'hF0, 1'b0); send(8'h12, 1'b0);
    chk("t2_shift_off", shift1, 0);
    exp_push(8'd49, 1'b1);
    send(8'h16, 1'b0);
    chk("t2_digit_caps", key_out1, 49);
    exp_push(8'd65, 1'b1);
    send(8'h1C, 1'b0);
    chk("t2_caps_letter", key_out1, 65);
    send(8'h59, 1'b0);
    chk("t2_rshift", shift1, 1);
    chk("t2_norep_rshift", shift0, 1);
    exp_push(8'd98, 1'b1);
    send(8'h32, 1'b0);
    send(8'hF0, 1'b0); send(8'h59, 1'b0);
    chk("t2_rshift_off", shift1, 0);
    drain();

    // extended prefix, keypad, specials
    do_reset();
    exp_push(8'd131, 1'b1);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    chk("t3_up", key_out1, 131);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    chk("t3_up_break", key_out1, 0);
    exp_push(8'd56, 1'b1);
    send(8'h75, 1'b0);
    chk("t3_kp8", key_out1, 56);
    send(8'hF0, 1'b0); send(8'h75, 1'b0);
    chk("t3_kp8_break", key_out1, 0);
    send(8'hE0, 1'b0); send(8'h12, 1'b0);
    chk("t3_fake_shift", shift1, 0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h12, 1'b0);
    exp_push(8'd47, 1'b1);
    send(8'hE0, 1'b0); send(8'h4A, 1'b0);
    chk("t3_kp_slash", key_out1, 47);
    exp_push(8'd128, 1'b1);
    send(8'h5A, 1'b0);
    chk("t3_enter", key_out1, 128);
    exp_push(8'd141, 1'b1);
    send(8'h05, 1'b0);
    chk("t3_f1", key_out1, 141);
    drain();

    // overflow and simultaneous push/pop at full
    do_reset();
    key_ready = 1'b0;
    exp_push(8'd97, 1'b1);  send(8'h1C, 1'b0);
    exp_push(8'd98, 1'b1);  send(8'h32, 1'b0);
    exp_push(8'd99, 1'b1);  send(8'h21, 1'b0);
    exp_push(8'd100, 1'b1); send(8'h23, 1'b0);
    chk("t4_full_valid", key_valid1, 1);
    chk("t4_full_no_ovf", overflow1, 0);
    exp_push(8'd101, 1'b1);
    send(8'h24, 1'b1);
    chk("t4_pushpop_no_ovf", overflow1, 0);
    send(8'h2B, 1'b0);
    chk("t4_overflow", overflow1, 1);
    chk("t4_norep_overflow", overflow0, 1);
    chk("t4_valid_after_drop", key_valid1, 1);
    chk("t4_key_out_dropped", key_out1, 102);
    drain();
    chk("t4_overflow_sticky", overflow1, 1);

    // caps autorepeat and typematic pushes
    do_reset();
    send(8'h58, 1'b0);
    chk("t5_caps_first", caps1, 1);
    send(8'h58, 1'b0); send(8'h58, 1'b0);
    chk("t5_caps_repeat", caps1, 1);
    send(8'hF0, 1'b0); send(8'h58, 1'b0);
    chk("t5_caps_release", caps1, 1);
    send(8'h58, 1'b0);
    chk("t5_caps_rearmed", caps1, 0);
    send(8'hF0, 1'b0); send(8'h58, 1'b0);
    exp_push(8'd97, 1'b1);
    exp_push(8'd97, 1'b0);
    exp_push(8'd97, 1'b0);
    send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    drain();

    // reset between prefix and code
    send(8'hE0, 1'b0);
    do_reset();
    exp_push(8'd56, 1'b1);
    send(8'h75, 1'b0);
    chk("t6_prefix_dropped", key_out1, 56);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
